// File: rtl/capture_ctrl_if.sv
// Sample stream in and ping-pong waveform-buffer write port out of the capture sequencer.
// Strobe semantics, no back-pressure: a sample is consumed in any cycle with sample_valid=1, and the buffer must take a write in any cycle with wr_en=1.
interface capture_ctrl_if #(
  parameter int DW = 12,
  parameter int AW = 10
) ();
  logic          sample_valid;
  logic [DW-1:0] sample;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_bank;
  logic          swap;

  modport master (
    input  sample_valid, sample,
    output wr_en, wr_bank, wr_addr, wr_data, rd_bank, swap
  );

  modport slave (
    output sample_valid, sample,
    input  wr_en, wr_bank, wr_addr, wr_data, rd_bank, swap
  );
endinterface

// File: rtl/capture_ctrl.sv
// Trigger/acquisition sequencer: waits for a level crossing or auto timeout, captures
// DEPTH samples into the back bank, then swaps banks on the next display frame start.
module capture_ctrl #(
  parameter int DW      = 12,
  parameter int DEPTH   = 600,
  parameter int AW      = 10,
  parameter int AUTO_TO = 4096
) (
  input  logic           clk,
  input  logic           reset,
  capture_ctrl_if.master bus,
  input  logic [DW-1:0]  trig_level,
  input  logic           trig_falling,
  input  logic           auto_mode,
  input  logic           run,
  input  logic           arm,
  input  logic           frame_start,
  output logic           busy,
  output logic           trig_forced,
  output logic [1:0]     dbg_state
);

  localparam int CW = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] cap_addr_q, cap_addr_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          rd_bank_q, rd_bank_d;
  logic          busy_q, busy_d;
  logic          trig_forced_q, trig_forced_d;
  logic          swap_q, swap_d;

  logic crossing;
  logic timeout;

  // The trigger inputs are used live, but only matter while ARMED.
  always_comb begin
    if (trig_falling)
      crossing = prev_valid_q && (prev_q >= trig_level) && (bus.sample < trig_level);
    else
      crossing = prev_valid_q && (prev_q < trig_level) && (bus.sample >= trig_level);
    timeout = auto_mode && (cnt_q == CW'(AUTO_TO - 1));
  end

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    cnt_d         = cnt_q;
    cap_addr_d    = cap_addr_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    rd_bank_d     = rd_bank_q;
    trig_forced_d = trig_forced_q;
    swap_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (arm || run) begin
          state_d      = ARMED;
          prev_valid_d = 1'b0;
          cnt_d        = '0;
        end
      end

      ARMED: begin
        if (bus.sample_valid) begin
          prev_d       = bus.sample;
          prev_valid_d = 1'b1;
          if (crossing || timeout) begin
            trig_forced_d = !crossing;
            wr_en_d       = 1'b1;
            wr_addr_d     = '0;
            wr_data_d     = bus.sample;
            cap_addr_d    = AW'(1);
            state_d       = (DEPTH == 1) ? DONE : CAPTURE;
          end else if (auto_mode) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      CAPTURE: begin
        if (bus.sample_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cap_addr_q;
          wr_data_d = bus.sample;
          if (cap_addr_q == AW'(DEPTH - 1))
            state_d = DONE;
          else
            cap_addr_d = cap_addr_q + 1'b1;
        end
      end

      DONE: begin
        // Samples arriving here are dropped; only frame_start moves us on.
        if (frame_start) begin
          rd_bank_d = ~rd_bank_q;
          swap_d    = 1'b1;
          if (run) begin
            state_d      = ARMED;
            prev_valid_d = 1'b0;
            cnt_d        = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ARMED) || (state_d == CAPTURE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      cnt_q         <= '0;
      cap_addr_q    <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_bank_q     <= 1'b0;
      busy_q        <= 1'b0;
      trig_forced_q <= 1'b0;
      swap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      cnt_q         <= cnt_d;
      cap_addr_q    <= cap_addr_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rd_bank_q     <= rd_bank_d;
      busy_q        <= busy_d;
      trig_forced_q <= trig_forced_d;
      swap_q        <= swap_d;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_bank  = ~rd_bank_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rd_bank  = rd_bank_q;
  assign bus.swap     = swap_q;
  assign busy         = busy_q;
  assign trig_forced  = trig_forced_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: trigger-detection vector table plus multi-cycle
// sequences for full captures, auto timeout, single-shot mode and mid-capture reset.
module tb_capture_ctrl;
  localparam int DW      = 12;
  localparam int AW      = 10;
  localparam int DEPTH   = 600;
  localparam int AUTO_TO = 16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] trig_level;
  logic          trig_falling, auto_mode, run, arm, frame_start;
  logic          busy, trig_forced;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  capture_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  capture_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .AUTO_TO(AUTO_TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .auto_mode    (auto_mode),
    .run          (run),
    .arm          (arm),
    .frame_start  (frame_start),
    .busy         (busy),
    .trig_forced  (trig_forced),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every write must match the next expected {addr, data}
  logic [AW+DW-1:0] exp_q[$];
  bit sb_en = 1'b0;
  int sb_writes = 0;
  int sb_bad = 0;

  always @(negedge clk) begin
    if (sb_en && bus.wr_en === 1'b1) begin
      sb_writes++;
      if (exp_q.size() == 0) sb_bad++;
      else if (exp_q.pop_front() !== {bus.wr_addr, bus.wr_data}) sb_bad++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks (all entered and left at a falling edge)
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.sample_valid = 1'b0;
    arm = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic strobe(input logic [DW-1:0] v);
    bus.sample_valid = 1'b1;
    bus.sample = v;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Back-to-back strobes base, base+1, ... expected at addresses a0, a0+1, ...
  task automatic stream(input int n, input int base, input int a0, output int gaps);
    gaps = 0;
    for (int k = 0; k < n; k++) begin
      bus.sample_valid = 1'b1;
      bus.sample = DW'(base + k);
      exp_q.push_back({AW'(a0 + k), DW'(base + k)});
      @(negedge clk);
      if (bus.wr_en !== 1'b1) gaps++;
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic sb_start();
    exp_q.delete();
    sb_writes = 0;
    sb_bad = 0;
    sb_en = 1'b1;
  endtask

  typedef struct {
    bit            rst;
    bit            falling;
    logic [DW-1:0] level;
    logic [DW-1:0] smp;
    bit            exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, input bit falling, input logic [DW-1:0] level,
                              input logic [DW-1:0] smp, input bit wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
    vec_t v;
    v.rst = rst; v.falling = falling; v.level = level; v.smp = smp;
    v.exp_wr = wr; v.exp_addr = a; v.exp_data = d;
    vecs.push_back(v);
  endfunction

  initial begin
    int gaps;
    int wr_seen;
    string tag;

    reset = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample = '0;
    trig_level = 12'd2048;
    trig_falling = 1'b0;
    auto_mode = 1'b0;
    run = 1'b1;
    arm = 1'b0;
    frame_start = 1'b0;

    // Rising through 2048 on a ramp
    add(1, 0, 12'd2048, 12'd2000, 0, 10'd0, 12'd0);
    add(0, 0, 12'd2048, 12'd2040, 0, 10'd0, 12'd0);
    add(0, 0, 12'd2048, 12'd2050, 1, 10'd0, 12'd2050);
    add(0, 0, 12'd2048, 12'd2060, 1, 10'd1, 12'd2060);
    // Falling through 100: 100 itself is not below the level
    add(1, 1, 12'd100,  12'd200,  0, 10'd0, 12'd0);
    add(0, 1, 12'd100,  12'd150,  0, 10'd0, 12'd0);
    add(0, 1, 12'd100,  12'd100,  0, 10'd0, 12'd0);
    add(0, 1, 12'd100,  12'd99,   1, 10'd0, 12'd99);
    add(0, 1, 12'd100,  12'd250,  1, 10'd1, 12'd250);
    // First sample after arming never triggers; sample == level counts as rising
    add(1, 0, 12'd2048, 12'd3000, 0, 10'd0, 12'd0);
    add(0, 0, 12'd2048, 12'd1000, 0, 10'd0, 12'd0);
    add(0, 0, 12'd2048, 12'd2048, 1, 10'd0, 12'd2048);
    // prev exactly at level then one below, and the top-of-range level
    add(1, 1, 12'd100,  12'd100,  0, 10'd0, 12'd0);
    add(0, 1, 12'd100,  12'd99,   1, 10'd0, 12'd99);
    add(1, 1, 12'd4095, 12'd4095, 0, 10'd0, 12'd0);
    add(0, 1, 12'd4095, 12'd4094, 1, 10'd0, 12'd4094);

    // Reset state
    #1;
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_rd_bank", bus.rd_bank, 0);
    check("rst_wr_bank", bus.wr_bank, 1);
    check("rst_busy", busy, 0);
    check("rst_trig_forced", trig_forced, 0);
    check("rst_swap", bus.swap, 0);
    check("rst_state", dbg_state, S_IDLE);

    // Table-driven trigger vectors
    foreach (vecs[i]) begin
      trig_falling = vecs[i].falling;
      trig_level = vecs[i].level;
      if (vecs[i].rst) do_reset();
      strobe(vecs[i].smp);
      tag = $sformatf("vec%0d", i);
      check({tag, "_wr_en"}, bus.wr_en, vecs[i].exp_wr);
      check({tag, "_busy"}, busy, 1);
      if (vecs[i].exp_wr) begin
        check({tag, "_addr"}, bus.wr_addr, vecs[i].exp_addr);
        check({tag, "_data"}, bus.wr_data, vecs[i].exp_data);
        check({tag, "_forced"}, trig_forced, 0);
      end
    end

    // Full capture with back-to-back strobes, then the swap corner cases
    run = 1'b1; trig_falling = 1'b0; trig_level = 12'd2048; auto_mode = 1'b0;
    do_reset();
    strobe(12'd2000);
    strobe(12'd2040);
    sb_start();
    stream(DEPTH - 1, 2050, 0, gaps);
    bus.sample_valid = 1'b1;
    bus.sample = DW'(2050 + DEPTH - 1);
    exp_q.push_back({AW'(DEPTH - 1), DW'(2050 + DEPTH - 1)});
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    if (bus.wr_en !== 1'b1) gaps++;
    check("cap_gaps", gaps, 0);
    check("cap_last_addr", bus.wr_addr, DEPTH - 1);
    check("cap_state_done", dbg_state, S_DONE);
    check("cap_busy_done", busy, 0);
    check("fs_on_done_entry_swap", bus.swap, 0);
    @(negedge clk);
    check("no_write_at_depth", bus.wr_en, 0);
    check("fs_on_done_entry_bank", bus.rd_bank, 0);
    check("done_holds", dbg_state, S_DONE);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    bus.sample_valid = 1'b0;
    check("swap_pulse", bus.swap, 1);
    check("swap_rd_bank", bus.rd_bank, 1);
    check("swap_wr_bank", bus.wr_bank, 0);
    check("swap_drops_sample", bus.wr_en, 0);
    check("swap_rearm", dbg_state, S_ARMED);
    @(negedge clk);
    check("swap_one_cycle", bus.swap, 0);
    #1;
    sb_en = 1'b0;
    check("cap_sb_writes", sb_writes, DEPTH);
    check("cap_sb_bad", sb_bad, 0);
    check("cap_sb_left", exp_q.size(), 0);

    // Reset at addr 300 of a re-armed capture (rd_bank is 1 here)
    @(negedge clk);
    strobe(12'd0);
    sb_start();
    stream(301, 2100, 0, gaps);
    #1;
    sb_en = 1'b0;
    check("mid_sb_writes", sb_writes, 301);
    check("mid_sb_bad", sb_bad, 0);
    check("mid_addr300", bus.wr_addr, 300);
    reset = 1'b0;
    #1;
    check("mid_rst_wr_en", bus.wr_en, 0);
    check("mid_rst_addr", bus.wr_addr, 0);
    check("mid_rst_data", bus.wr_data, 0);
    check("mid_rst_rd_bank", bus.rd_bank, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", dbg_state, S_IDLE);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("mid_no_swap", bus.swap, 0);
    check("mid_no_bank_flip", bus.rd_bank, 0);

    // Auto timeout: constant 500 never crosses 2048
    auto_mode = 1'b1;
    do_reset();
    wr_seen = 0;
    for (int k = 0; k < AUTO_TO - 1; k++) begin
      strobe(12'd500);
      if (bus.wr_en === 1'b1) wr_seen++;
    end
    check("auto_early_writes", wr_seen, 0);
    strobe(12'd500);
    check("auto_wr_en", bus.wr_en, 1);
    check("auto_addr", bus.wr_addr, 0);
    check("auto_data", bus.wr_data, 500);
    check("auto_forced", trig_forced, 1);
    check("auto_state", dbg_state, S_CAPTURE);

    auto_mode = 1'b0;
    do_reset();
    wr_seen = 0;
    for (int k = 0; k < 3 * AUTO_TO; k++) begin
      strobe(12'd500);
      if (bus.wr_en === 1'b1) wr_seen++;
    end
    check("noauto_writes", wr_seen, 0);
    check("noauto_state", dbg_state, S_ARMED);

    // Single-shot mode
    run = 1'b0;
    do_reset();
    check("ss_idle", dbg_state, S_IDLE);
    check("ss_idle_busy", busy, 0);
    wr_seen = 0;
    for (int k = 0; k < 4; k++) begin
      strobe(12'd100 + 12'(k * 2000));
      if (bus.wr_en === 1'b1) wr_seen++;
    end
    check("ss_idle_writes", wr_seen, 0);
    pulse_arm();
    check("ss_armed", dbg_state, S_ARMED);
    strobe(12'd100);
    sb_start();
    stream(10, 3000, 0, gaps);
    pulse_arm();
    check("ss_arm_while_busy", dbg_state, S_CAPTURE);
    stream(DEPTH - 10, 3010, 10, gaps);
    check("ss_gaps", gaps, 0);
    check("ss_done", dbg_state, S_DONE);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("ss_swap", bus.swap, 1);
    check("ss_rd_bank", bus.rd_bank, 1);
    check("ss_back_idle", dbg_state, S_IDLE);
    #1;
    sb_en = 1'b0;
    check("ss_sb_writes", sb_writes, DEPTH);
    check("ss_sb_bad", sb_bad, 0);
    @(negedge clk);
    wr_seen = 0;
    for (int k = 0; k < 5; k++) begin
      strobe(12'd4000 - 12'(k * 900));
      if (bus.wr_en === 1'b1) wr_seen++;
    end
    check("ss_after_writes", wr_seen, 0);
    check("ss_after_idle", dbg_state, S_IDLE);
    pulse_arm();
    check("ss_rearm", dbg_state, S_ARMED);
    check("ss_rearm_busy", busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
